stream_demux2: RTL and testbench
================================

// Module: stream_demux2
// PURPOSE
//   Stream demultiplexer: routes one valid/ready input stream to one of two output streams (A/B)
//   by a per-word select bit. It is the inverse of the 2:1 "multiplexer" selector, where control=0
//   picks dataA and control=1 picks dataB. Each output has its own FIFO, so a stalled output never
//   blocks traffic bound for the other. It sits between a bus producer and two independent consumers.
// PARAMETERS
//   WIDTH  8   data word width in bits
//   DEPTH  2   entries per output FIFO; power of two, >= 2
//   CNT_W  16  width of per-output transfer counters
// PORTS
//   clk          in   1      clock; all state updates on posedge clk
//   rst          in   1      synchronous reset, active-high
//   in_valid     in   1      input word valid
//   in_ready     out  1      input word accepted this cycle when in_valid && in_ready
//   in_data      in   WIDTH  input word
//   in_sel       in   1      route select: 0 -> A, 1 -> B; must be stable while in_valid is high
//   out_a_valid  out  1      A FIFO non-empty
//   out_a_ready  in   1      A consumer pops the head when out_a_valid && out_a_ready
//   out_a_data   out  WIDTH  A FIFO head word
//   out_b_valid  out  1      B FIFO non-empty
//   out_b_ready  in   1      B consumer pops the head
//   out_b_data   out  WIDTH  B FIFO head word
//   cnt_a        out  CNT_W  words popped on A, modulo 2^CNT_W
//   cnt_b        out  CNT_W  words popped on B, modulo 2^CNT_W
// BEHAVIOUR
//   - Reset, synchronous and active-high:
//       - Both FIFOs become empty, with pointers at 0 and storage zeroed.
//       - out_*_valid=0, out_*_data=0, cnt_a=cnt_b=0; in_ready=1 from the first cycle after reset.
//       - Reset mid-operation discards all buffered words; no output valid is seen after rst.
//   - in_ready is combinational: in_ready = !full[in_sel]. It uses registered full only, with no
//     same-cycle pop passthrough. A full FIFO refuses a push even if it is popped in that cycle.
//   - Push: on in_valid && in_ready, in_data is written at the selected FIFO's wr_ptr, then wr_ptr++.
//   - Pop: on out_x_valid && out_x_ready, rd_ptr++ and cnt_x++ (wraps to 0 past 2^CNT_W-1).
//   - Latency: a word accepted at edge N is visible on out_x_valid/out_x_data after edge N.
//     Minimum 1 cycle; no combinational in->out data path.
//   - Ordering: strict FIFO order within each output. There is no ordering relation between A and B.
//   - Simultaneous push and pop on the same FIFO, when not full: both happen and occupancy is unchanged.
//   - Simultaneous pops on A and B are independent.
//   - Pointers are log2(DEPTH)+1 bits.
//       - empty = (wr_ptr == rd_ptr).
//       - full = MSBs differ and the low bits are equal.
//       - Wrap-around is natural binary overflow.
//   - out_x_data = mem[rd_ptr]. It is meaningful only when out_x_valid=1 and is stable while
//     valid && !ready.
//   - in_valid=0 never changes state. in_sel is ignored when in_valid=0.
// STRUCTURE
//   - Package stream_demux_pkg:
//       - localparam SEL_A=1'b0, SEL_B=1'b1
//       - function clog2 for the pointer width
//   - Sub-module stream_fifo #(WIDTH, DEPTH):
//       - ports clk, rst, push, push_data, full, pop, head_data, empty
//       - instantiated twice, as u_fifo_a and u_fifo_b
//   - Top level: in_ready/push steering, valid = !empty, and the two counters.
// TESTING
//   1. Reset: rst=1 for 2 cycles, then 0 -> in_ready=1, out_a_valid=out_b_valid=0, cnt_a=cnt_b=0.
//   2. Routing: both readies=1; push 8'h11 with sel=0, then 8'h22 with sel=1 on consecutive cycles
//      -> A shows 8'h11 one cycle after its push and B shows 8'h22 one cycle after its push;
//      cnt_a=1, cnt_b=1.
//   3. Full: out_a_ready=0, DEPTH=2; offer 01, 02, 03 with sel=0
//      -> 01 and 02 are accepted, then in_ready=0 while 03 waits. Raise out_a_ready
//      -> pops give 01 then 02, and 03 is accepted once a slot frees.
//   4. No head-of-line blocking: A full and out_a_ready=0; push 8'hB0..B3 with sel=1 and
//      out_b_ready=1 -> in_ready=1 throughout and B emits B0..B3 in order; A is unchanged.
//   5. Counter wrap: CNT_W=4; pop 17 words on A -> cnt_a reads 15 after 15 pops, 0 after 16,
//      and 1 after 17.
//   6. Reset mid-operation: A holding 2 words, B holding 1 word; assert rst for 1 cycle
//      -> the next cycle shows both valids 0, in_ready=1 and counters 0. The buffered words never appear.

Source files
------------

// File: rtl/stream_demux_pkg.sv
// Shared constants and helpers for the two-way stream demultiplexer.
package stream_demux_pkg;

   localparam logic SEL_A = 1'b0;
   localparam logic SEL_B = 1'b1;

   // Ceiling log2 for pointer sizing; evaluated at elaboration only.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((1 << r) < value) r++;
      end
      return r;
   endfunction

endpackage

// File: rtl/stream_fifo.sv
// Synchronous FIFO with one extra pointer bit, used to tell full apart from empty.
module stream_fifo
   import stream_demux_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   output logic             full,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic             empty
);

   localparam int AW = clog2(DEPTH);

   logic [AW:0]                 wr_ptr;
   logic [AW:0]                 rd_ptr;
   logic [DEPTH-1:0][WIDTH-1:0] mem;

   assign empty     = (wr_ptr == rd_ptr);
   assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign head_data = mem[rd_ptr[AW-1:0]];

   // Guards make the FIFO safe even if a caller ignores full/empty.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         mem    <= '0;
      end else begin
         if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
            wr_ptr              <= wr_ptr + 1'b1;
         end
         if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
      end
   end

endmodule

// File: rtl/stream_demux2.sv
// Routes one valid/ready stream to output A or B by in_sel, with a FIFO per
// output so a stalled consumer never blocks the other.
module stream_demux2
   import stream_demux_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_sel,
   output logic             out_a_valid,
   input  logic             out_a_ready,
   output logic [WIDTH-1:0] out_a_data,
   output logic             out_b_valid,
   input  logic             out_b_ready,
   output logic [WIDTH-1:0] out_b_data,
   output logic [CNT_W-1:0] cnt_a,
   output logic [CNT_W-1:0] cnt_b
);

   logic full_a, full_b, empty_a, empty_b;
   logic push_a, push_b, pop_a, pop_b;

   // Registered full only: a full FIFO refuses a push even when it pops in the same cycle.
   assign in_ready = (in_sel == SEL_B) ? !full_b : !full_a;
   assign push_a   = in_valid && in_ready && (in_sel == SEL_A);
   assign push_b   = in_valid && in_ready && (in_sel == SEL_B);

   assign out_a_valid = !empty_a;
   assign out_b_valid = !empty_b;
   assign pop_a       = out_a_valid && out_a_ready;
   assign pop_b       = out_b_valid && out_b_ready;

   stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
      .clk       (clk),
      .rst       (rst),
      .push      (push_a),
      .push_data (in_data),
      .full      (full_a),
      .pop       (pop_a),
      .head_data (out_a_data),
      .empty     (empty_a)
   );

   stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
      .clk       (clk),
      .rst       (rst),
      .push      (push_b),
      .push_data (in_data),
      .full      (full_b),
      .pop       (pop_b),
      .head_data (out_b_data),
      .empty     (empty_b)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_a <= '0;
         cnt_b <= '0;
      end else begin
         if (pop_a) cnt_a <= cnt_a + 1'b1;
         if (pop_b) cnt_b <= cnt_b + 1'b1;
      end
   end

endmodule

// File: tb/tb_stream_demux2.sv
// Scoreboard bench for stream_demux2: directed pushes queue expected words,
// a negedge monitor checks every pop against them.
module tb_stream_demux2;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid, in_ready, in_sel;
   logic [7:0] in_data;
   logic       out_a_valid, out_a_ready, out_b_valid, out_b_ready;
   logic [7:0] out_a_data, out_b_data;
   logic [3:0] cnt_a, cnt_b;

   int         vectors = 0;
   int         miscompares = 0;
   logic [7:0] exp_a[$];
   logic [7:0] exp_b[$];

   stream_demux2 #(.WIDTH(8), .DEPTH(2), .CNT_W(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .in_sel      (in_sel),
      .out_a_valid (out_a_valid),
      .out_a_ready (out_a_ready),
      .out_a_data  (out_a_data),
      .out_b_valid (out_b_valid),
      .out_b_ready (out_b_ready),
      .out_b_data  (out_b_data),
      .cnt_a       (cnt_a),
      .cnt_b       (cnt_b)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every visible word must be expected; every pop must match in order.
   always @(negedge clk) begin
      if (!rst) begin
         if (out_a_valid && exp_a.size() == 0) chk("a_unexpected_valid", 1, 0);
         else if (out_a_valid && out_a_ready) chk("a_data", out_a_data, exp_a.pop_front());
         if (out_b_valid && exp_b.size() == 0) chk("b_unexpected_valid", 1, 0);
         else if (out_b_valid && out_b_ready) chk("b_data", out_b_data, exp_b.pop_front());
      end
   end

   // Offers one word; returns how many extra negedges in_ready stayed low.
   task automatic push(input logic sel, input logic [7:0] d, output int waits);
      waits    = 0;
      in_valid = 1'b1;
      in_sel   = sel;
      in_data  = d;
      @(negedge clk);
      while (!in_ready && waits < 50) begin
         @(negedge clk);
         waits++;
      end
      if (!in_ready) chk("push_timeout", 0, 1);
      else if (sel) exp_b.push_back(d);
      else exp_a.push_back(d);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   int w;

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
      out_a_ready = 1'b0; out_b_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      chk("rst_in_ready", in_ready, 1);
      chk("rst_a_valid", out_a_valid, 0);
      chk("rst_b_valid", out_b_valid, 0);
      chk("rst_cnt_a", cnt_a, 0);
      chk("rst_cnt_b", cnt_b, 0);

      // Routing with one-cycle latency
      out_a_ready = 1'b1; out_b_ready = 1'b1;
      push(1'b0, 8'h11, w);
      chk("route_a_valid", out_a_valid, 1);
      chk("route_a_data", out_a_data, 8'h11);
      push(1'b1, 8'h22, w);
      chk("route_b_valid", out_b_valid, 1);
      chk("route_b_data", out_b_data, 8'h22);
      @(posedge clk); #1;
      chk("route_cnt_a", cnt_a, 1);
      chk("route_cnt_b", cnt_b, 1);

      // Full A: third word must wait until a slot frees
      out_a_ready = 1'b0;
      push(1'b0, 8'h01, w); chk("full_wait_01", w, 0);
      push(1'b0, 8'h02, w); chk("full_wait_02", w, 0);
      fork
         push(1'b0, 8'h03, w);
         begin
            repeat (2) @(negedge clk);
            chk("full_in_ready_low", in_ready, 0);
            @(posedge clk);
            #1 out_a_ready = 1'b1;
         end
      join
      chk("full_03_waited", (w > 0), 1);
      repeat (4) @(posedge clk); #1;
      chk("full_cnt_a", cnt_a, 4);
      chk("full_drained", out_a_valid, 0);

      // No head-of-line blocking: A full and stalled, B flows
      out_a_ready = 1'b0;
      push(1'b0, 8'hA0, w);
      push(1'b0, 8'hA1, w);
      for (int i = 0; i < 4; i++) begin
         push(1'b1, 8'hB0 + 8'(i), w);
         chk("hol_b_no_wait", w, 0);
      end
      chk("hol_a_valid", out_a_valid, 1);
      chk("hol_a_head", out_a_data, 8'hA0);
      repeat (2) @(posedge clk); #1;
      chk("hol_cnt_b", cnt_b, 5);
      out_a_ready = 1'b1;
      repeat (4) @(posedge clk); #1;
      chk("hol_cnt_a", cnt_a, 6);

      // Reset mid-operation discards buffered words
      out_a_ready = 1'b0; out_b_ready = 1'b0;
      push(1'b0, 8'h61, w);
      push(1'b0, 8'h62, w);
      push(1'b1, 8'h71, w);
      rst = 1'b1;
      exp_a.delete();
      exp_b.delete();
      @(posedge clk);
      #1 rst = 1'b0;
      chk("mid_rst_a_valid", out_a_valid, 0);
      chk("mid_rst_b_valid", out_b_valid, 0);
      chk("mid_rst_in_ready", in_ready, 1);
      chk("mid_rst_cnt_a", cnt_a, 0);
      chk("mid_rst_cnt_b", cnt_b, 0);
      out_a_ready = 1'b1; out_b_ready = 1'b1;
      repeat (4) @(posedge clk); #1;

      // 4-bit counter wrap on A
      for (int i = 0; i < 17; i++) begin
         push(1'b0, 8'(8'h80 + i), w);
         @(posedge clk); #1;
         if (i == 14) chk("wrap_cnt_15", cnt_a, 15);
         if (i == 15) chk("wrap_cnt_0", cnt_a, 0);
         if (i == 16) chk("wrap_cnt_1", cnt_a, 1);
      end

      repeat (3) @(posedge clk); #1;
      chk("end_exp_a_empty", exp_a.size(), 0);
      chk("end_exp_b_empty", exp_b.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
